div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider for the EX stage. Implements RISC-V M-extension DIV, DIVU, REM and REMU.
- It is the requesting side of the pipeline-control interface. It drives the EX stall request into the control block while iterating.
- It consumes the pipeline hold and flush indications coming back, so it neither loses nor duplicates a result.
- Radix-2 restoring algorithm, one quotient bit per cycle, with fast paths for divide-by-zero and signed overflow.

---
 rtl/div_unit.sv | 154 +++++++++++++++
 tb/tb_div_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU/REM/REMU).
// Raises the EX stall request while iterating and presents the result for one
// cycle in DONE. It stays in DONE while the stage is held, and an annul drops
// any work in progress.
module div_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            hold_i,
    input  logic            annul_i,
    output logic            stallreq_o,
    output logic            ready_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [1:0]        op_q, op_d;

    // Operand decode for an instruction arriving in IDLE
    logic            accept, is_signed, dvd_neg, dvs_neg, div_zero, overflow, fast;
    logic [XLEN-1:0] dvd_abs, dvs_abs, fast_res;

    assign accept    = (state_q == StIdle) && start_i && !annul_i;
    assign is_signed = !op_i[0];
    assign dvd_neg   = is_signed & dividend_i[XLEN-1];
    assign dvs_neg   = is_signed & divisor_i[XLEN-1];
    assign dvd_abs   = dvd_neg ? (~dividend_i + 1'b1) : dividend_i;
    assign dvs_abs   = dvs_neg ? (~divisor_i + 1'b1) : divisor_i;
    assign div_zero  = (divisor_i == '0);
    assign overflow  = is_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                       && (divisor_i == '1);
    assign fast      = div_zero | overflow;
    // Overflow quotient equals the dividend itself (most negative value)
    assign fast_res  = div_zero ? (op_i[1] ? dividend_i : '1)
                                : (op_i[1] ? '0 : dividend_i);

    // One restoring iteration: dividend bits shift out of the quotient register's MSB
    logic [XLEN:0]   rem_sh, diff, step_rem;
    logic [XLEN-1:0] step_quo, quo_fix, rem_fix;
    logic            last_iter;

    assign rem_sh    = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    assign diff      = rem_sh - {1'b0, dvs_q};
    assign step_rem  = diff[XLEN] ? rem_sh : diff;
    assign step_quo  = {quo_q[XLEN-2:0], ~diff[XLEN]};
    assign quo_fix   = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
    assign rem_fix   = neg_rem_q ? (~step_rem[XLEN-1:0] + 1'b1) : step_rem[XLEN-1:0];
    assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; annul always returns to IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = fast ? StDone : StBusy;
            StBusy: begin
                if (annul_i)        state_d = StIdle;
                else if (last_iter) state_d = StDone;
            end
            StDone: if (annul_i || !hold_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic; reset forces the handshake outputs low even with start_i high
    always_comb begin
        stallreq_o = 1'b0;
        ready_o    = 1'b0;
        if (rst) begin
            unique case (state_q)
                StIdle:  stallreq_o = start_i && !annul_i;
                StBusy:  stallreq_o = !annul_i;
                StDone:  ready_o    = !annul_i;
                default: ;
            endcase
        end
    end

    assign result_o = result_q;

    // Datapath next-state: load on accept, iterate in BUSY, latch final result
    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        op_d      = op_q;
        result_d  = result_q;
        if (accept) begin
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = dvd_abs;
            dvs_d     = dvs_abs;
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
            op_d      = op_i;
            if (fast) result_d = fast_res;
        end else if (state_q == StBusy && !annul_i) begin
            cnt_d = cnt_q + CNT_W'(1);
            rem_d = step_rem;
            quo_d = step_quo;
            if (last_iter) result_d = op_q[1] ? rem_fix : quo_fix;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            op_q      <= '0;
            result_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            op_q      <= op_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected results, one task
// per scenario.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        hold_i;
    logic        annul_i;
    logic        stallreq_o;
    logic        ready_o;
    logic [31:0] result_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .hold_i     (hold_i),
        .annul_i    (annul_i),
        .stallreq_o (stallreq_o),
        .ready_o    (ready_o),
        .result_o   (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model straight from the ISA definition
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    // Drive a new instruction in the cycle after the next rising edge
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        start_i    = 1'b1;
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        exp_q.push_back(model(op, a, b));
    endtask

    // Count stall cycles until ready_o, bounded
    task automatic wait_done(output int stalls, output bit ok);
        stalls = 0;
        ok     = 1'b0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (ready_o) begin
                ok = 1'b1;
                break;
            end
            if (stallreq_o) stalls++;
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_reset;
        #3;
        n_checks++;
        if (stallreq_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: stall=%b ready=%b result=%h, required 0 0 0",
                     stallreq_o, ready_o, result_o);
        end
        #9 rst = 1'b1;
    endtask

    // Run one queued divide and compare latency and result
    task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_stalls);
        int          stalls;
        bit          ok;
        logic [31:0] exp;
        issue(op, a, b);
        wait_done(stalls, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s_timeout: ready_o never rose, required within 40 cycles", name);
            if (exp_q.size() != 0) exp_q.delete(0);
            return;
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (result_o !== exp) begin
            n_errors++;
            $display("FAIL %s_result: got %h, required %h", name, result_o, exp);
        end
        n_checks++;
        if (stalls !== exp_stalls) begin
            n_errors++;
            $display("FAIL %s_stalls: got %0d, required %0d", name, stalls, exp_stalls);
        end
        n_checks++;
        if (stallreq_o !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_done_stall: got %b, required 0", name, stallreq_o);
        end
    endtask

    task automatic test_unsigned_back_to_back;
        run_one("divu_100_7", 2'b01, 32'd100, 32'd7, 33);
        run_one("remu_100_7", 2'b11, 32'd100, 32'd7, 33);
    endtask

    task automatic test_signed;
        run_one("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 33);
        run_one("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 33);
        run_one("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 33);
        run_one("div_rand", 2'b00, 32'hDEAD_BEEF, 32'h0000_1234, 33);
    endtask

    task automatic test_fast_path;
        run_one("div_by_zero", 2'b00, 32'd5, 32'd0, 1);
        run_one("remu_by_zero", 2'b11, 32'd5, 32'd0, 1);
        run_one("div_overflow", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        run_one("rem_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    endtask

    task automatic test_hold;
        run_one("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 33);
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            n_checks++;
            if (ready_o !== 1'b1 || stallreq_o !== 1'b0 || result_o !== 32'hFFFF_FFFF) begin
                n_errors++;
                $display("FAIL hold_cycle%0d: ready=%b stall=%b result=%h, required 1 0 ffffffff",
                         i, ready_o, stallreq_o, result_o);
            end
        end
        hold_i  = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #2;
        n_checks++;
        if (ready_o !== 1'b0 || stallreq_o !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_release: ready=%b stall=%b, required 0 0", ready_o, stallreq_o);
        end
    endtask

    task automatic test_annul;
        issue(2'b01, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #2;
        annul_i = 1'b1;
        #1;
        n_checks++;
        if (stallreq_o !== 1'b0 || ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL annul_cycle: stall=%b ready=%b, required 0 0", stallreq_o, ready_o);
        end
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        #1;
        n_checks++;
        if (stallreq_o !== 1'b0 || ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL annul_idle: stall=%b ready=%b, required 0 0", stallreq_o, ready_o);
        end
        run_one("divu_9_3", 2'b01, 32'd9, 32'd3, 33);
    endtask

    task automatic test_async_reset;
        issue(2'b01, 32'd50, 32'd5);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if (stallreq_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 32'd0) begin
            n_errors++;
            $display("FAIL async_reset: stall=%b ready=%b result=%h, required 0 0 0",
                     stallreq_o, ready_o, result_o);
        end
        exp_q.delete();
        @(posedge clk);
        #2;
        start_i = 1'b0;
        #3;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            n_checks++;
            if (stallreq_o !== 1'b0 || ready_o !== 1'b0) begin
                n_errors++;
                $display("FAIL post_reset_idle%0d: stall=%b ready=%b, required 0 0",
                         i, stallreq_o, ready_o);
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        start_i    = 1'b0;
        op_i       = 2'b00;
        dividend_i = 32'd0;
        divisor_i  = 32'd0;
        hold_i     = 1'b0;
        annul_i    = 1'b0;
        test_reset();
        test_unsigned_back_to_back();
        test_signed();
        test_fast_path();
        test_hold();
        test_annul();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
